// File: rtl/hazard_md_ctrl_pkg.sv
// Shared pipeline definitions for the hazard / mult-div controller.
// Holds the default register-address and Tuse/Tnew widths, the Tuse/Tnew
// encodings and the default mult/div occupancy lengths.
package hazard_md_ctrl_pkg;

   localparam int RAW_W        = 5;   // register-address width
   localparam int TW_W         = 2;   // Tuse/Tnew width
   localparam int MULT_CYC_DEF = 5;   // mult/multu busy cycles
   localparam int DIV_CYC_DEF  = 10;  // div/divu busy cycles

   // Tuse / Tnew: number of cycles until a value is needed / produced.
   typedef enum logic [TW_W-1:0] {
      T_0 = 2'd0,
      T_1 = 2'd1,
      T_2 = 2'd2,
      T_3 = 2'd3
   } tcyc_e;

   // Occupancy length for an MD operation.
   function automatic int md_cycles(input logic is_div, input int mult_cyc, input int div_cyc);
      return is_div ? div_cyc : mult_cyc;
   endfunction

endpackage

// File: rtl/hazard_md_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//   master : pipeline side, drives D/E/M stage information, reads stall/enables
//   slave  : controller side
interface hazard_md_ctrl_if
   import hazard_md_ctrl_pkg::*;
#(
   parameter int RAW = RAW_W,
   parameter int TW  = TW_W,
   parameter int SW  = 32
);
   logic [RAW-1:0] d_rs, d_rt;
   logic [TW-1:0]  d_rs_tuse, d_rt_tuse;
   logic           d_md_use;
   logic [RAW-1:0] e_a3, m_a3;
   logic           e_we, m_we;
   logic [TW-1:0]  e_tnew, m_tnew;
   logic           e_md_start, e_md_div;
   logic           stat_clr;
   logic           stall, pc_we, fd_we, de_clr;
   logic           md_busy, md_done;
   logic [SW-1:0]  stall_cnt;

   modport master (
      output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_md_use,
             e_a3, m_a3, e_we, m_we, e_tnew, m_tnew,
             e_md_start, e_md_div, stat_clr,
      input  stall, pc_we, fd_we, de_clr, md_busy, md_done, stall_cnt
   );

   modport slave (
      input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_md_use,
             e_a3, m_a3, e_we, m_we, e_tnew, m_tnew,
             e_md_start, e_md_div, stat_clr,
      output stall, pc_we, fd_we, de_clr, md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/hazard_md_ctrl_md_busy_tracker.sv
// Mult/div occupancy tracker.
//   clk, rst_n : clock, async active-low reset (aborts any operation)
//   start      : E holds a mult/div this cycle
//   is_div     : qualifies start (1 = div)
//   md_busy    : unit occupied (counter non-zero)
//   md_done    : last busy cycle
module md_busy_tracker
   import hazard_md_ctrl_pkg::*;
#(
   parameter int CW       = 4,
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic is_div,
   output logic md_busy,
   output logic md_done
);
   localparam logic [CW-1:0] MULT_LD = CW'(md_cycles(1'b0, MULT_CYC, DIV_CYC));
   localparam logic [CW-1:0] DIV_LD  = CW'(md_cycles(1'b1, MULT_CYC, DIV_CYC));

   logic [CW-1:0] cnt;

   // A start while already busy is dropped; the running count continues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (start && cnt == '0)
         cnt <= is_div ? DIV_LD : MULT_LD;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign md_busy = (cnt != '0);
   assign md_done = (cnt == CW'(1));
endmodule

// File: rtl/hazard_md_ctrl.sv
// Hazard detection and stall control for a 5-stage pipeline with a
// multi-cycle mult/div unit, plus a saturating stalled-cycle counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : hazard_md_ctrl_if slave (D/E/M info in, stall/enables/stats out)
module hazard_md_ctrl
   import hazard_md_ctrl_pkg::*;
#(
   parameter int RAW      = RAW_W,
   parameter int TW       = TW_W,
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CW       = 4,
   parameter int SW       = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   hazard_md_ctrl_if.slave bus
);
   // A producer blocks a consumer when it writes the same non-zero register
   // and the value will not exist by the time the consumer needs it.
   function automatic logic hit(input logic [RAW-1:0] src, input logic [TW-1:0] tuse,
                                input logic [RAW-1:0] a3, input logic we,
                                input logic [TW-1:0] tnew);
      return (src != '0) && we && (src == a3) && (tuse < tnew);
   endfunction

   logic          stall_rs, stall_rt, stall_md, stall;
   logic          md_busy;
   logic [SW-1:0] stall_cnt;

   assign stall_rs = hit(bus.d_rs, bus.d_rs_tuse, bus.e_a3, bus.e_we, bus.e_tnew)
                   | hit(bus.d_rs, bus.d_rs_tuse, bus.m_a3, bus.m_we, bus.m_tnew);
   assign stall_rt = hit(bus.d_rt, bus.d_rt_tuse, bus.e_a3, bus.e_we, bus.e_tnew)
                   | hit(bus.d_rt, bus.d_rt_tuse, bus.m_a3, bus.m_we, bus.m_tnew);
   // The start cycle itself is not yet visible in the busy counter.
   assign stall_md = bus.d_md_use & (md_busy | bus.e_md_start);
   assign stall    = stall_rs | stall_rt | stall_md;

   md_busy_tracker #(
      .CW       (CW),
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_trk (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (bus.e_md_start),
      .is_div  (bus.e_md_div),
      .md_busy (md_busy),
      .md_done (bus.md_done)
   );

   // Clear wins over increment; the count holds at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (bus.stat_clr)
         stall_cnt <= '0;
      else if (stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign bus.stall     = stall;
   assign bus.pc_we     = ~stall;
   assign bus.fd_we     = ~stall;
   assign bus.de_clr    = stall;
   assign bus.md_busy   = md_busy;
   assign bus.stall_cnt = stall_cnt;
endmodule
